fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/byte_packer.sv | 36 +++
 rtl/fifo_burst_reader.sv | 146 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared widths, state encoding and length saturation for the FIFO burst reader.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LANES       = 4;
    localparam int unsigned MAX_BURST   = 16;
    localparam int unsigned LEN_W       = 5;
    localparam int unsigned LANE_CNT_W  = 3;
    localparam int unsigned LANE_IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PUSH,
        DONE
    } rd_state_e;

    // Lengths above one FIFO's worth are clamped to MAX_BURST.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] raw_len);
        return (raw_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : raw_len;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs bytes into one little-endian word, tracking which lanes hold valid data.
module byte_packer
    import fifo_pkg::*;
(
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   wr_en_i,
    input  logic [LANE_IDX_W-1:0]  lane_i,
    input  logic [FIFO_DATA_W-1:0] byte_i,
    output logic [WORD_W-1:0]      data_o,
    output logic [LANES-1:0]       keep_o
);

    logic [WORD_W-1:0] data_q;
    logic [LANES-1:0]  keep_q;

    // Lanes never written stay zero with keep low, so partial words come out clean.
    always_ff @(posedge clock) begin
        if (rst || clear_i) begin
            data_q <= '0;
            keep_q <= '0;
        end else if (wr_en_i) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (lane_i == LANE_IDX_W'(l)) begin
                    data_q[l*FIFO_DATA_W +: FIFO_DATA_W] <= byte_i;
                    keep_q[l]                            <= 1'b1;
                end
            end
        end
    end

    assign data_o = data_q;
    assign keep_o = keep_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a burst of bytes from a 16x8 registered-output FIFO and emits them
// as 32-bit little-endian words with keep/last over a valid/ready handshake.
module fifo_burst_reader
    import fifo_pkg::*;
(
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    output logic                   fifo_rd,
    input  logic                   fifo_empty,
    input  logic [FIFO_DATA_W-1:0] fifo_dout,
    output logic [WORD_W-1:0]      word_data,
    output logic [LANES-1:0]       word_keep,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   word_last
);

    rd_state_e             state_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issued_q;
    logic [LEN_W-1:0]      captured_q;
    logic [LANE_CNT_W-1:0] issued_word_q;
    logic [LANE_CNT_W-1:0] captured_word_q;
    logic                  pending_q;
    logic                  fifo_rd_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  word_valid_q;
    logic                  word_last_q;

    logic [LEN_W-1:0]      issued_d;
    logic [LANE_CNT_W-1:0] issued_word_d;
    logic                  grant;
    logic                  rd_next;
    logic                  capture;
    logic                  last_byte;
    logic                  word_full;
    logic                  handshake;

    // A request against an empty FIFO is not a grant and advances nothing.
    assign grant         = fifo_rd_q & ~fifo_empty;
    assign issued_d      = issued_q + LEN_W'(grant);
    assign issued_word_d = issued_word_q + LANE_CNT_W'(grant);
    assign rd_next       = (issued_d < len_q) && (issued_word_d < LANE_CNT_W'(LANES));
    assign capture       = (state_q == FETCH) && pending_q;
    assign last_byte     = (captured_q + LEN_W'(1)) == len_q;
    assign word_full     = (captured_word_q + LANE_CNT_W'(1)) == LANE_CNT_W'(LANES);
    assign handshake     = (state_q == PUSH) && word_valid_q && word_ready;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q         <= IDLE;
            len_q           <= '0;
            issued_q        <= '0;
            captured_q      <= '0;
            issued_word_q   <= '0;
            captured_word_q <= '0;
            pending_q       <= 1'b0;
            fifo_rd_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            word_valid_q    <= 1'b0;
            word_last_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        issued_q        <= '0;
                        captured_q      <= '0;
                        issued_word_q   <= '0;
                        captured_word_q <= '0;
                        pending_q       <= 1'b0;
                        if (len == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q   <= FETCH;
                            len_q     <= sat_len(len);
                            busy_q    <= 1'b1;
                            fifo_rd_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    issued_q      <= issued_d;
                    issued_word_q <= issued_word_d;
                    pending_q     <= grant;
                    fifo_rd_q     <= rd_next;
                    // Data from last cycle's grant lands in the next free lane.
                    if (pending_q) begin
                        captured_q      <= captured_q + LEN_W'(1);
                        captured_word_q <= captured_word_q + LANE_CNT_W'(1);
                        if (word_full || last_byte) begin
                            state_q      <= PUSH;
                            fifo_rd_q    <= 1'b0;
                            word_valid_q <= 1'b1;
                            word_last_q  <= last_byte;
                        end
                    end
                end
                PUSH: begin
                    if (word_valid_q && word_ready) begin
                        word_valid_q    <= 1'b0;
                        word_last_q     <= 1'b0;
                        issued_word_q   <= '0;
                        captured_word_q <= '0;
                        if (word_last_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= FETCH;
                            fifo_rd_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    byte_packer u_packer (
        .clock   (clock),
        .rst     (rst),
        .clear_i (handshake),
        .wr_en_i (capture),
        .lane_i  (captured_word_q[LANE_IDX_W-1:0]),
        .byte_i  (fifo_dout),
        .data_o  (word_data),
        .keep_o  (word_keep)
    );

    assign fifo_rd    = fifo_rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_valid = word_valid_q;
    assign word_last  = word_last_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, scoreboard of expected words,
// a table of burst lengths and directed multi-cycle corner cases.
module tb_fifo_burst_reader;

    logic        clock = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic        fifo_rd;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] word_data;
    logic [3:0]  word_keep;
    logic        word_valid;
    logic        word_ready;
    logic        word_last;

    always #5 clock = ~clock;

    fifo_burst_reader dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .word_data  (word_data),
        .word_keep  (word_keep),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last)
    );

    // 16x8 FIFO model: registered read data one cycle after a granted read.
    logic [7:0] fmem [16];
    logic [3:0] wp, rp;
    logic [4:0] fcount;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       do_rd, do_wr;

    assign fifo_empty = (fcount == 5'd0);
    assign do_rd      = fifo_rd && (fcount != 5'd0);
    assign do_wr      = wr_en && ((fcount != 5'd16) || do_rd);

    always @(posedge clock) begin
        if (rst) begin
            wp        <= 4'd0;
            rp        <= 4'd0;
            fcount    <= 5'd0;
            fifo_dout <= 8'd0;
        end else begin
            if (do_rd) begin
                fifo_dout <= fmem[rp];
                rp        <= rp + 4'd1;
            end
            if (do_wr) begin
                fmem[wp] <= wr_data;
                wp       <= wp + 4'd1;
            end
            fcount <= fcount + 5'(do_wr) - 5'(do_rd);
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct {
        logic [4:0] len;
        int         n_load;
        int         exp_words;
        logic [3:0] exp_last_keep;
    } vec_t;

    localparam int N_VEC = 7;

    word_t      exp_q[$];
    logic [7:0] src_q[$];
    vec_t       vecs[N_VEC];

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_grants   = 0;
    int   n_words    = 0;
    int   n_dones    = 0;
    int   n_rd_push  = 0;
    int   n_dbl_done = 0;
    logic prev_done  = 1'b0;
    logic [3:0] last_keep_seen = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Observe the cycle about to end (inputs already applied), then advance one clock.
    task automatic tick();
        word_t w;
        if (word_valid === 1'b1 && word_ready === 1'b1) begin
            n_words++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%08h expected none", word_data);
            end else begin
                w = exp_q.pop_front();
                chk("word_data", word_data, w.data);
                chk("word_keep", 32'(word_keep), 32'(w.keep));
                chk("word_last", 32'(word_last), 32'(w.last));
            end
            if (word_last === 1'b1) last_keep_seen = word_keep;
        end
        if (fifo_rd === 1'b1 && fifo_empty === 1'b0) n_grants++;
        if (fifo_rd === 1'b1 && word_valid === 1'b1) n_rd_push++;
        if (done === 1'b1) begin
            n_dones++;
            if (prev_done) n_dbl_done++;
        end
        prev_done = (done === 1'b1);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic fifo_put(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_seq(input int n, input logic [7:0] seed, input logic [7:0] step);
        logic [7:0] v;
        src_q.delete();
        v = seed;
        for (int i = 0; i < n; i++) begin
            src_q.push_back(v);
            fifo_put(v);
            v = v + step;
        end
    endtask

    // Expected words for the first n bytes of src_q.
    task automatic expect_words(input int n);
        word_t w;
        for (int base = 0; base < n; base += 4) begin
            w = '0;
            for (int l = 0; l < 4; l++) begin
                if (base + l < n) begin
                    w.data[8*l +: 8] = src_q[base + l];
                    w.keep[l]        = 1'b1;
                end
            end
            w.last = (base + 4 >= n);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_burst(input logic [4:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 5'd0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit rnd_ready);
        int d0;
        d0 = n_dones;
        for (int i = 0; i < budget; i++) begin
            if (n_dones != d0) break;
            if (rnd_ready) word_ready = 1'($urandom_range(0, 1));
            tick();
        end
        word_ready = 1'b1;
        n_checks++;
        if (n_dones == d0) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
        tick();
        tick();
        chk({name, "_done_once"}, 32'(n_dones - d0), 32'd1);
    endtask

    initial begin
        int g0, w0, d0;

        vecs[0] = '{5'd1,  1,  1, 4'h1};
        vecs[1] = '{5'd4,  4,  1, 4'hF};
        vecs[2] = '{5'd7,  7,  2, 4'h7};
        vecs[3] = '{5'd13, 13, 4, 4'h1};
        vecs[4] = '{5'd16, 16, 4, 4'hF};
        vecs[5] = '{5'd20, 16, 4, 4'hF};
        vecs[6] = '{5'd31, 16, 4, 4'hF};

        rst        = 1'b1;
        start      = 1'b0;
        len        = 5'd0;
        wr_en      = 1'b0;
        wr_data    = 8'd0;
        word_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_fifo_rd",    32'(fifo_rd),    32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_last",  32'(word_last),  32'd0);
        chk("rst_word_keep",  32'(word_keep),  32'd0);
        chk("rst_word_data",  word_data,       32'd0);
        rst = 1'b0;
        tick();

        // Preloaded 01..08, len=8, always ready.
        load_seq(8, 8'h01, 8'h01);
        exp_q.push_back('{32'h04030201, 4'hF, 1'b0});
        exp_q.push_back('{32'h08070605, 4'hF, 1'b1});
        g0 = n_grants;
        w0 = n_words;
        start_burst(5'd8);
        chk("b8_busy", 32'(busy), 32'd1);
        wait_done("b8", 100, 1'b0);
        chk("b8_grants", 32'(n_grants - g0), 32'd8);
        chk("b8_words",  32'(n_words - w0),  32'd2);
        chk("b8_busy_end", 32'(busy), 32'd0);

        // AA..EE, len=5: one full word then a single-lane last word.
        load_seq(5, 8'hAA, 8'h11);
        exp_q.push_back('{32'hDDCCBBAA, 4'hF, 1'b0});
        exp_q.push_back('{32'h000000EE, 4'h1, 1'b1});
        start_burst(5'd5);
        wait_done("b5", 100, 1'b0);
        chk("b5_last_keep", 32'(last_keep_seen), 32'h1);

        // len=0: no reads, no words, done two cycles after start.
        g0 = n_grants;
        w0 = n_words;
        d0 = n_dones;
        start_burst(5'd0);
        chk("len0_c1_done",  32'(done),       32'd0);
        chk("len0_c1_busy",  32'(busy),       32'd0);
        chk("len0_c1_valid", 32'(word_valid), 32'd0);
        tick();
        chk("len0_c2_done",  32'(done),       32'd1);
        chk("len0_c2_rd",    32'(fifo_rd),    32'd0);
        tick();
        chk("len0_c3_done",  32'(done),       32'd0);
        tick();
        chk("len0_grants",   32'(n_grants - g0), 32'd0);
        chk("len0_words",    32'(n_words - w0),  32'd0);
        chk("len0_dones",    32'(n_dones - d0),  32'd1);

        // len=3 with one byte present; two more arrive ten cycles later.
        src_q.delete();
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        src_q.push_back(8'h33);
        fifo_put(8'h11);
        expect_words(3);
        g0 = n_grants;
        start_burst(5'd3);
        for (int i = 0; i < 9; i++) tick();
        chk("stall_rd",     32'(fifo_rd),        32'd1);
        chk("stall_empty",  32'(fifo_empty),     32'd1);
        chk("stall_valid",  32'(word_valid),     32'd0);
        chk("stall_busy",   32'(busy),           32'd1);
        chk("stall_grants", 32'(n_grants - g0),  32'd1);
        fifo_put(8'h22);
        fifo_put(8'h33);
        wait_done("stall", 100, 1'b0);
        chk("stall_grants_end", 32'(n_grants - g0), 32'd3);
        chk("stall_last_keep",  32'(last_keep_seen), 32'h7);

        // len=8 with the first word held off for six cycles.
        load_seq(8, 8'h31, 8'h01);
        expect_words(8);
        word_ready = 1'b0;
        start_burst(5'd8);
        for (int i = 0; i < 20 && word_valid !== 1'b1; i++) tick();
        chk("hold_valid", 32'(word_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("hold_data", word_data,     32'h34333231);
            chk("hold_rd",   32'(fifo_rd),  32'd0);
            tick();
        end
        word_ready = 1'b1;
        wait_done("hold", 100, 1'b0);

        // Length table with random backpressure.
        for (int i = 0; i < N_VEC; i++) begin
            load_seq(vecs[i].n_load, 8'(64 + i * 16), 8'h01);
            expect_words(vecs[i].n_load);
            g0 = n_grants;
            w0 = n_words;
            start_burst(vecs[i].len);
            wait_done("vec", 400, 1'b1);
            chk("vec_grants",    32'(n_grants - g0),  32'(vecs[i].n_load));
            chk("vec_words",     32'(n_words - w0),   32'(vecs[i].exp_words));
            chk("vec_last_keep", 32'(last_keep_seen), 32'(vecs[i].exp_last_keep));
            chk("vec_fifo_left", 32'(fcount),         32'd0);
        end

        // Reset during FETCH of a len=16 burst, then a clean len=4 burst.
        load_seq(16, 8'h80, 8'h01);
        w0 = n_words;
        start_burst(5'd16);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_done",  32'(done),       32'd0);
        chk("mid_rst_rd",    32'(fifo_rd),    32'd0);
        chk("mid_rst_valid", 32'(word_valid), 32'd0);
        chk("mid_rst_last",  32'(word_last),  32'd0);
        chk("mid_rst_keep",  32'(word_keep),  32'd0);
        chk("mid_rst_data",  word_data,       32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_rst_no_word", 32'(n_words - w0), 32'd0);
        load_seq(4, 8'h50, 8'h01);
        expect_words(4);
        start_burst(5'd4);
        wait_done("post_rst", 100, 1'b0);
        chk("post_rst_words", 32'(n_words - w0), 32'd1);

        chk("rd_during_push",  32'(n_rd_push),    32'd0);
        chk("done_wider_than_1", 32'(n_dbl_done), 32'd0);
        chk("exp_q_drained",   32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
